// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius input checker.
package genius_pkg;

    localparam int unsigned BTN_W = 4;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_WRONG   = 2'd1;
    localparam logic [1:0] FAIL_MULTI   = 2'd2;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE
    } state_e;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [BTN_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/genius_input_checker_if.sv
// Control handshake and sequence-ROM bus between the game controller/ROM and the checker.
interface genius_input_checker_if
    import genius_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] round_len;
    logic [ADDR_W-1:0] seq_addr;
    logic [BTN_W-1:0]  seq_data;
    logic              busy;
    logic              round_ok;
    logic              fail;
    logic [1:0]        fail_code;
    logic [ADDR_W-1:0] step_cnt;

    // Controller and ROM side.
    modport master (
        output start, round_len, seq_data,
        input  seq_addr, busy, round_ok, fail, fail_code, step_cnt
    );

    // Checker side.
    modport slave (
        input  start, round_len, seq_data,
        output seq_addr, busy, round_ok, fail, fail_code, step_cnt
    );
endinterface

// File: rtl/genius_btn_sync.sv
// Button conditioning: 2-flop synchroniser, optional debouncer, previous-sample flop,
// and press/release/one-hot decode. Debouncer enabled by GENIUS_CHECK_DEBOUNCE_EN.
module genius_btn_sync
    import genius_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BTN_W-1:0] buttons,
    output logic             press,
    output logic             released,
    output logic             onehot,
    output logic [BTN_W-1:0] level
);
    logic [BTN_W-1:0] s1, s2, prev;

    // Two-stage synchroniser for the asynchronous buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= buttons;
            s2 <= s1;
        end
    end

`ifdef GENIUS_CHECK_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    logic [BTN_W-1:0] cand, db;
    logic [CNT_W-1:0] cnt, run;

    // Length of the current run of identical s2 values, this cycle included.
    always_comb begin
        run = cnt;
        if (s2 != cand) begin
            run = CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            run = cnt + 1'b1;
        end
    end

    // Debounced level follows s2 once it has been stable for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= '0;
            cnt  <= '0;
            db   <= '0;
        end else begin
            cand <= s2;
            cnt  <= run;
            if (run == CNT_MAX) begin
                db <= s2;
            end
        end
    end

    assign level = db;
`else
    // Parameter kept so both builds share one instantiation.
    if (DEBOUNCE_CYC == 0) begin : g_debounce_unused
    end

    assign level = s2;
`endif

    // Previous sample, so a level held from before start never looks like a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    assign press    = (level != '0) && (prev == '0);
    assign released = (level == '0);
    assign onehot   = is_onehot(level);

endmodule

// File: rtl/genius_input_checker.sv
// Genius player-input checker: walks the colour ROM for one round and compares each
// button press with the expected colour. Optional debouncer: GENIUS_CHECK_DEBOUNCE_EN.
module genius_input_checker
    import genius_pkg::*;
#(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned TIMEOUT_CYC  = 50000000,
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BTN_W-1:0] buttons,
    genius_input_checker_if.slave bus
);
    localparam int unsigned TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0]  STEP_MAX   = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [1:0]          code_q, code_d;
    logic                ok_q, ok_d;
    logic                fail_q, fail_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;

    logic                btn_press, btn_released, btn_onehot;
    logic [BTN_W-1:0]    btn_level;

    genius_btn_sync #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .buttons  (buttons),
        .press    (btn_press),
        .released (btn_released),
        .onehot   (btn_onehot),
        .level    (btn_level)
    );

    // Round sequencing: next state, ROM address, counters and result pulses.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        step_d  = step_q;
        code_d  = code_q;
        ok_d    = 1'b0;
        fail_d  = 1'b0;
        timer_d = timer_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = bus.round_len;
                    addr_d  = '0;
                    step_d  = '0;
                    code_d  = FAIL_NONE;
                    timer_d = '0;
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                timer_d = timer_q + 1'b1;
                // A press in the timeout cycle takes priority over the timeout.
                if (btn_press) begin
                    if (!btn_onehot) begin
                        fail_d  = 1'b1;
                        code_d  = FAIL_MULTI;
                        state_d = IDLE;
                    end else if (btn_level != bus.seq_data) begin
                        fail_d  = 1'b1;
                        code_d  = FAIL_WRONG;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_RELEASE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    fail_d  = 1'b1;
                    code_d  = FAIL_TIMEOUT;
                    state_d = IDLE;
                end
            end
            WAIT_RELEASE: begin
                if (btn_released) begin
                    step_d = (step_q == STEP_MAX) ? step_q : step_q + 1'b1;
                    if (addr_q == len_q) begin
                        ok_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        timer_d = '0;
                        state_d = WAIT_PRESS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            step_q  <= '0;
            code_q  <= FAIL_NONE;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            step_q  <= step_d;
            code_q  <= code_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    assign bus.seq_addr  = addr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.round_ok  = ok_q;
    assign bus.fail      = fail_q;
    assign bus.fail_code = code_q;
    assign bus.step_cnt  = step_q;

endmodule

// File: doc/genius_input_checker.md
Name: genius_input_checker

Overview:
- Player-side consumer of the Genius colour-sequence ROM: drives `seq_addr` and reads back the one-hot expected colour on `seq_data`.
- Samples the four player buttons, detects each press, and checks it against the expected colour.
- Steps through one round of length `round_len+1`, then reports success or the failure cause to the game controller.

Parameters:
- ADDR_W, 4, width of sequence address / round index
- TIMEOUT_CYC, 50000000, max cycles allowed between step start and a press
- DEBOUNCE_CYC, 500000, stable cycles required per button level (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: begin checking a round (ignored while busy)
- round_len  in  ADDR_W  index of last step to check (0 = one step); sampled on accepted start
- buttons  in  4  raw asynchronous player buttons, bit0..bit3 = colours matching ROM one-hot
- seq_addr  out  ADDR_W  address to sequence ROM
- seq_data  in  4  one-hot expected colour from ROM (combinational from seq_addr)
- busy  out  1  high from accepted start until round_ok/fail
- round_ok  out  1  one-cycle pulse: whole round entered correctly
- fail  out  1  one-cycle pulse: round failed
- fail_code  out  2  cause, valid with fail, held until next accepted start
- step_cnt  out  ADDR_W  steps correctly completed in current/last round

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - Reset values: seq_addr=0, busy=0, round_ok=0, fail=0, fail_code=0, step_cnt=0, state IDLE, sync flops 0.
- Input conditioning: buttons pass a 2-flop synchroniser, giving stage s2. A third flop holds the previous sample p.
  - Press event: s2!=0 and p==0.
  - Release event: s2==0.
  - A button held when start is accepted produces no press until fully released.
- State machine:
  - IDLE: start -> latch round_len, seq_addr=0, step_cnt=0, fail_code=0, busy=1, timer=0 -> WAIT_PRESS.
  - WAIT_PRESS: timer increments every cycle.
    - Press with s2 not one-hot -> fail, code 2 (MULTI) -> IDLE.
    - Press with s2 != seq_data -> fail, code 1 (WRONG) -> IDLE.
    - Press with s2 == seq_data -> WAIT_RELEASE.
    - No press and timer==TIMEOUT_CYC-1 -> fail, code 3 (TIMEOUT) -> IDLE.
    - Press and timeout in the same cycle: the press wins.
  - WAIT_RELEASE: no timeout; additional buttons are ignored. On release event, step_cnt+1, then:
    - seq_addr==round_len -> round_ok pulse -> IDLE.
    - Otherwise seq_addr+1, timer=0 -> WAIT_PRESS.
- Outputs: round_ok and fail are registered; busy drops in the same cycle they pulse.
- Latency: a raw button change before clock edge k is decided at edge k+2. round_ok/fail is high for the cycle after edge k+2.
- Wrap: round_len=2^ADDR_W-1 is legal. seq_addr never increments past round_len, so it never wraps. step_cnt saturates at 2^ADDR_W-1.
- start while busy: ignored, no state change.
- Reset mid-round: immediate return to reset values; no pulse is generated.

Optional Feature:
- Macro: GENIUS_CHECK_DEBOUNCE_EN.
- Defined: s2 feeds a debouncer.
  - The debounced level updates only after s2 has held the same value for DEBOUNCE_CYC consecutive cycles.
  - Press/release detection and the one-hot check use the debounced level.
  - Decision latency becomes edge k+2+DEBOUNCE_CYC.
- Undefined: s2 is used directly and DEBOUNCE_CYC is unused.

Decomposition:
- Package genius_pkg:
  - BTN_W=4.
  - Fail codes FAIL_NONE=2'd0, FAIL_WRONG=2'd1, FAIL_MULTI=2'd2, FAIL_TIMEOUT=2'd3.
  - State enum IDLE/WAIT_PRESS/WAIT_RELEASE.
- Sub-module genius_btn_sync contains:
  - the synchroniser,
  - the optional debouncer,
  - the previous-sample flop,
  - press/release/one-hot outputs.
- The checker FSM, timer and counters stay in genius_input_checker.

Test Plan:
- Correct round: ROM model returns 0001, 1000, 0100 for addr 0..2; round_len=2; press/release 0001, 1000, 0100 -> one round_ok pulse, step_cnt=3, fail never asserted.
- Wrong colour: same setup; press 0001, release, then press 0100 -> fail with fail_code=1, step_cnt=1, seq_addr=1, busy=0.
- Multi-press: at step 0, press buttons=0011 from 0000 -> fail_code=2.
- Timeout: TIMEOUT_CYC=20, start and no press -> fail_code=3 exactly 20 cycles after entering WAIT_PRESS. A press landing on cycle 20 is accepted instead.
- Held-at-start: buttons=0001 held while start pulses -> no decision until release; then a fresh 0001 press is accepted. A start pulse while busy is ignored.
- Reset mid-round: rst_n low during WAIT_RELEASE -> all outputs reset asynchronously, no pulse; after release of reset, a new start works normally. Rerun the suite with GENIUS_CHECK_DEBOUNCE_EN, DEBOUNCE_CYC=4, including a 2-cycle glitch on buttons that must be ignored.
